// File: rtl/issue_sched.sv
// In-order issue scheduler: takes the longest in-order prefix of the four
// decoded lanes that fits the free execution units, binds each accepted
// lane to a unit port, serialises CSR/exception lanes and tracks the
// multi-cycle divider occupancy.
module issue_sched #(
   parameter int NUM_ALU     = 2,
   parameter int DIV_LATENCY = 34,
   parameter int DIV_CNT_W   = 6
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       fetch0_valid_i,
   input  logic       fetch0_instr_exec_i,
   input  logic       fetch0_instr_lsu_i,
   input  logic       fetch0_instr_branch_i,
   input  logic       fetch0_instr_mul_i,
   input  logic       fetch0_instr_div_i,
   input  logic       fetch0_instr_csr_i,
   input  logic       fetch0_instr_invalid_i,
   input  logic       fetch0_fault_fetch_i,
   input  logic       fetch0_fault_page_i,
   input  logic       fetch1_valid_i,
   input  logic       fetch1_instr_exec_i,
   input  logic       fetch1_instr_lsu_i,
   input  logic       fetch1_instr_branch_i,
   input  logic       fetch1_instr_mul_i,
   input  logic       fetch1_instr_div_i,
   input  logic       fetch1_instr_csr_i,
   input  logic       fetch1_instr_invalid_i,
   input  logic       fetch1_fault_fetch_i,
   input  logic       fetch1_fault_page_i,
   input  logic       fetch2_valid_i,
   input  logic       fetch2_instr_exec_i,
   input  logic       fetch2_instr_lsu_i,
   input  logic       fetch2_instr_branch_i,
   input  logic       fetch2_instr_mul_i,
   input  logic       fetch2_instr_div_i,
   input  logic       fetch2_instr_csr_i,
   input  logic       fetch2_instr_invalid_i,
   input  logic       fetch2_fault_fetch_i,
   input  logic       fetch2_fault_page_i,
   input  logic       fetch3_valid_i,
   input  logic       fetch3_instr_exec_i,
   input  logic       fetch3_instr_lsu_i,
   input  logic       fetch3_instr_branch_i,
   input  logic       fetch3_instr_mul_i,
   input  logic       fetch3_instr_div_i,
   input  logic       fetch3_instr_csr_i,
   input  logic       fetch3_instr_invalid_i,
   input  logic       fetch3_fault_fetch_i,
   input  logic       fetch3_fault_page_i,
   input  logic       lsu_ready_i,
   input  logic       stall_i,
   input  logic       csr_complete_i,
   input  logic       branch_request_i,
   output logic       fetch0_accept_o,
   output logic       fetch1_accept_o,
   output logic       fetch2_accept_o,
   output logic       fetch3_accept_o,
   output logic [2:0] issue0_port_o,
   output logic [2:0] issue1_port_o,
   output logic [2:0] issue2_port_o,
   output logic [2:0] issue3_port_o,
   output logic       div_busy_o,
   output logic       serialising_o,
   output logic [2:0] issue_count_o
);

   localparam logic [2:0] P_ALU0 = 3'd0;
   localparam logic [2:0] P_ALU1 = 3'd1;
   localparam logic [2:0] P_LSU  = 3'd2;
   localparam logic [2:0] P_BR   = 3'd3;
   localparam logic [2:0] P_MUL  = 3'd4;
   localparam logic [2:0] P_DIV  = 3'd5;
   localparam logic [2:0] P_CSR  = 3'd6;
   localparam logic [2:0] P_EXC  = 3'd7;

   typedef enum logic {ST_ISSUE, ST_WAIT_SER} state_t;

   state_t                 state_reg, state_next;
   logic [DIV_CNT_W-1:0]   div_cnt_reg, div_cnt_next;

   logic [3:0] valid_v, exec_v, lsu_v, br_v, mul_v, div_v, csr_v, exc_v;
   logic [2:0] cls  [4];
   logic [2:0] port [4];
   logic [3:0] accept;
   logic       blocked, ser_issue, div_issue, div_free;
   logic       lsu_used, br_used, mul_used, div_used;
   int         alu_used;

   assign valid_v = {fetch3_valid_i, fetch2_valid_i, fetch1_valid_i, fetch0_valid_i};
   assign exec_v  = {fetch3_instr_exec_i, fetch2_instr_exec_i, fetch1_instr_exec_i, fetch0_instr_exec_i};
   assign lsu_v   = {fetch3_instr_lsu_i, fetch2_instr_lsu_i, fetch1_instr_lsu_i, fetch0_instr_lsu_i};
   assign br_v    = {fetch3_instr_branch_i, fetch2_instr_branch_i, fetch1_instr_branch_i, fetch0_instr_branch_i};
   assign mul_v   = {fetch3_instr_mul_i, fetch2_instr_mul_i, fetch1_instr_mul_i, fetch0_instr_mul_i};
   assign div_v   = {fetch3_instr_div_i, fetch2_instr_div_i, fetch1_instr_div_i, fetch0_instr_div_i};
   assign csr_v   = {fetch3_instr_csr_i, fetch2_instr_csr_i, fetch1_instr_csr_i, fetch0_instr_csr_i};
   assign exc_v   = {fetch3_instr_invalid_i | fetch3_fault_fetch_i | fetch3_fault_page_i,
                     fetch2_instr_invalid_i | fetch2_fault_fetch_i | fetch2_fault_page_i,
                     fetch1_instr_invalid_i | fetch1_fault_fetch_i | fetch1_fault_page_i,
                     fetch0_instr_invalid_i | fetch0_fault_fetch_i | fetch0_fault_page_i};

   assign div_free = (div_cnt_reg == '0);

   // Per-lane unit class by priority; an explicit exec flag and "no flag" both land on ALU.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cls
         assign cls[gi] = exc_v[gi] ? P_EXC :
                          csr_v[gi] ? P_CSR :
                          div_v[gi] ? P_DIV :
                          mul_v[gi] ? P_MUL :
                          lsu_v[gi] ? P_LSU :
                          br_v[gi]  ? P_BR  :
                          (exec_v[gi] ? P_ALU0 : P_ALU0);
      end
   endgenerate

   // In-order scan: accept lanes until the first one that is invalid or finds its unit taken.
   always_comb begin
      accept    = '0;
      for (int i = 0; i < 4; i++) port[i] = 3'd0;
      alu_used  = 0;
      lsu_used  = 1'b0;
      br_used   = 1'b0;
      mul_used  = 1'b0;
      div_used  = 1'b0;
      ser_issue = 1'b0;
      div_issue = 1'b0;
      blocked   = rst_i | branch_request_i | stall_i | (state_reg == ST_WAIT_SER);
      for (int i = 0; i < 4; i++) begin
         if (!blocked) begin
            if (!valid_v[i]) begin
               blocked = 1'b1;
            end else begin
               case (cls[i])
                  P_EXC, P_CSR: begin
                     // Serialising lanes go alone from lane 0 and always end the scan.
                     if (i == 0 && div_free) begin
                        accept[i] = 1'b1;
                        port[i]   = cls[i];
                        ser_issue = 1'b1;
                     end
                     blocked = 1'b1;
                  end
                  P_DIV: begin
                     if (div_free && !div_used) begin
                        accept[i] = 1'b1;
                        port[i]   = P_DIV;
                        div_used  = 1'b1;
                        div_issue = 1'b1;
                     end else blocked = 1'b1;
                  end
                  P_MUL: begin
                     if (!mul_used) begin
                        accept[i] = 1'b1;
                        port[i]   = P_MUL;
                        mul_used  = 1'b1;
                     end else blocked = 1'b1;
                  end
                  P_LSU: begin
                     if (lsu_ready_i && !lsu_used) begin
                        accept[i] = 1'b1;
                        port[i]   = P_LSU;
                        lsu_used  = 1'b1;
                     end else blocked = 1'b1;
                  end
                  P_BR: begin
                     if (!br_used) begin
                        accept[i] = 1'b1;
                        port[i]   = P_BR;
                        br_used   = 1'b1;
                     end else blocked = 1'b1;
                  end
                  default: begin
                     if (alu_used < NUM_ALU) begin
                        accept[i] = 1'b1;
                        port[i]   = (alu_used == 0) ? P_ALU0 : P_ALU1;
                        alu_used  = alu_used + 1;
                     end else blocked = 1'b1;
                  end
               endcase
            end
         end
      end
   end

   // Next state: redirect beats stall, stall beats CSR completion; divider always runs down.
   always_comb begin
      state_next   = state_reg;
      div_cnt_next = div_cnt_reg;
      if (branch_request_i)
         state_next = ST_ISSUE;
      else if (stall_i)
         state_next = state_reg;
      else if (state_reg == ST_WAIT_SER && csr_complete_i)
         state_next = ST_ISSUE;
      else if (ser_issue)
         state_next = ST_WAIT_SER;

      if (div_issue)
         div_cnt_next = DIV_CNT_W'(DIV_LATENCY);
      else if (!div_free)
         div_cnt_next = div_cnt_reg - DIV_CNT_W'(1);
   end

   // State and divider counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= ST_ISSUE;
         div_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         div_cnt_reg <= div_cnt_next;
      end
   end

   assign fetch0_accept_o = accept[0];
   assign fetch1_accept_o = accept[1];
   assign fetch2_accept_o = accept[2];
   assign fetch3_accept_o = accept[3];
   assign issue0_port_o   = port[0];
   assign issue1_port_o   = port[1];
   assign issue2_port_o   = port[2];
   assign issue3_port_o   = port[3];
   assign issue_count_o   = {2'b00, accept[0]} + {2'b00, accept[1]} +
                            {2'b00, accept[2]} + {2'b00, accept[3]};
   assign div_busy_o      = !rst_i && !div_free;
   assign serialising_o   = !rst_i && (state_reg == ST_WAIT_SER);

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: a table of single-cycle issue vectors plus
// hand-written sequences for serialisation, divider occupancy and reset.
module tb_issue_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, lsu_rdy, stall, csr_done, brq;
   logic [3:0] v, ex, ls, br, mu, dv, cs, iv, ffe, fpg;
   logic [3:0] acc;
   logic [2:0] p0, p1, p2, p3, cnt;
   logic       busy, ser;

   int total = 0;
   int bad   = 0;

   localparam int K_ALU = 0, K_EXEC = 1, K_LSU = 2, K_BR = 3, K_MUL = 4, K_DIV = 5,
                  K_CSR = 6, K_INV = 7, K_FF = 8, K_FP = 9, K_CSRDIV = 10,
                  K_MULLSU = 11, K_LSUBR = 12;

   issue_sched dut (
      .clk_i(clk), .rst_i(rst),
      .fetch0_valid_i(v[0]), .fetch0_instr_exec_i(ex[0]), .fetch0_instr_lsu_i(ls[0]),
      .fetch0_instr_branch_i(br[0]), .fetch0_instr_mul_i(mu[0]), .fetch0_instr_div_i(dv[0]),
      .fetch0_instr_csr_i(cs[0]), .fetch0_instr_invalid_i(iv[0]),
      .fetch0_fault_fetch_i(ffe[0]), .fetch0_fault_page_i(fpg[0]),
      .fetch1_valid_i(v[1]), .fetch1_instr_exec_i(ex[1]), .fetch1_instr_lsu_i(ls[1]),
      .fetch1_instr_branch_i(br[1]), .fetch1_instr_mul_i(mu[1]), .fetch1_instr_div_i(dv[1]),
      .fetch1_instr_csr_i(cs[1]), .fetch1_instr_invalid_i(iv[1]),
      .fetch1_fault_fetch_i(ffe[1]), .fetch1_fault_page_i(fpg[1]),
      .fetch2_valid_i(v[2]), .fetch2_instr_exec_i(ex[2]), .fetch2_instr_lsu_i(ls[2]),
      .fetch2_instr_branch_i(br[2]), .fetch2_instr_mul_i(mu[2]), .fetch2_instr_div_i(dv[2]),
      .fetch2_instr_csr_i(cs[2]), .fetch2_instr_invalid_i(iv[2]),
      .fetch2_fault_fetch_i(ffe[2]), .fetch2_fault_page_i(fpg[2]),
      .fetch3_valid_i(v[3]), .fetch3_instr_exec_i(ex[3]), .fetch3_instr_lsu_i(ls[3]),
      .fetch3_instr_branch_i(br[3]), .fetch3_instr_mul_i(mu[3]), .fetch3_instr_div_i(dv[3]),
      .fetch3_instr_csr_i(cs[3]), .fetch3_instr_invalid_i(iv[3]),
      .fetch3_fault_fetch_i(ffe[3]), .fetch3_fault_page_i(fpg[3]),
      .lsu_ready_i(lsu_rdy), .stall_i(stall), .csr_complete_i(csr_done),
      .branch_request_i(brq),
      .fetch0_accept_o(acc[0]), .fetch1_accept_o(acc[1]),
      .fetch2_accept_o(acc[2]), .fetch3_accept_o(acc[3]),
      .issue0_port_o(p0), .issue1_port_o(p1), .issue2_port_o(p2), .issue3_port_o(p3),
      .div_busy_o(busy), .serialising_o(ser), .issue_count_o(cnt)
   );

   typedef struct {
      string       nm;
      logic [3:0]  valid;
      logic [15:0] kinds;   // one nibble per lane, lane 0 in the low nibble
      logic        lsu;
      logic        stl;
      logic        brq;
      logic [3:0]  acc;
      logic [11:0] ports;   // 3 bits per lane, lane 0 in the low bits
   } vec_t;

   vec_t tbl[16];

   task automatic set_lanes(input logic [3:0] valid, input logic [15:0] kinds);
      int k;
      v = valid; ex = '0; ls = '0; br = '0; mu = '0; dv = '0; cs = '0;
      iv = '0; ffe = '0; fpg = '0;
      for (int n = 0; n < 4; n++) begin
         k = int'(kinds[n*4 +: 4]);
         case (k)
            K_EXEC:   ex[n] = 1'b1;
            K_LSU:    ls[n] = 1'b1;
            K_BR:     br[n] = 1'b1;
            K_MUL:    mu[n] = 1'b1;
            K_DIV:    dv[n] = 1'b1;
            K_CSR:    cs[n] = 1'b1;
            K_INV:    iv[n] = 1'b1;
            K_FF:     ffe[n] = 1'b1;
            K_FP:     fpg[n] = 1'b1;
            K_CSRDIV: begin cs[n] = 1'b1; dv[n] = 1'b1; end
            K_MULLSU: begin mu[n] = 1'b1; ls[n] = 1'b1; end
            K_LSUBR:  begin ls[n] = 1'b1; br[n] = 1'b1; end
            default:  ;
         endcase
      end
   endtask

   task automatic check(input string nm, input logic [3:0] eacc, input logic [11:0] eports,
                        input logic ebusy, input logic eser, input logic allp);
      logic [11:0] aports;
      logic [2:0]  ecnt;
      logic        ok;
      aports = {p3, p2, p1, p0};
      ecnt   = 3'($countones(eacc));
      ok     = (acc === eacc) && (cnt === ecnt) && (busy === ebusy) && (ser === eser);
      for (int n = 0; n < 4; n++)
         if ((eacc[n] || allp) && (aports[n*3 +: 3] !== eports[n*3 +: 3])) ok = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got acc=%b cnt=%0d ports=%o busy=%b ser=%b, want acc=%b cnt=%0d ports=%o busy=%b ser=%b",
                  nm, acc, cnt, aports, busy, ser, eacc, ecnt, eports, ebusy, eser);
      end else begin
         $display("ok   %s: acc=%b cnt=%0d ports=%o busy=%b ser=%b", nm, acc, cnt, aports, busy, ser);
      end
   endtask

   // One cycle: inputs already driven, sample at negedge, advance past the next posedge.
   task automatic cyc(input string nm, input logic [3:0] eacc, input logic [11:0] eports,
                      input logic ebusy, input logic eser, input logic allp);
      @(negedge clk);
      check(nm, eacc, eports, ebusy, eser, allp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{"alu4",       4'b1111, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0011, {3'd0, 3'd0, 3'd1, 3'd0}};
      tbl[1]  = '{"mix_lsu",    4'b1111, 16'h4320, 1'b1, 1'b0, 1'b0, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd0}};
      tbl[2]  = '{"mix_nolsu",  4'b1111, 16'h4320, 1'b0, 1'b0, 1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}};
      tbl[3]  = '{"lane0_idle", 4'b1110, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0000, 12'd0};
      tbl[4]  = '{"alu3_lsu",   4'b1111, 16'h2000, 1'b1, 1'b0, 1'b0, 4'b0011, {3'd0, 3'd0, 3'd1, 3'd0}};
      tbl[5]  = '{"lsu2",       4'b1111, 16'h0022, 1'b1, 1'b0, 1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}};
      tbl[6]  = '{"exec_br2",   4'b1111, 16'h0331, 1'b1, 1'b0, 1'b0, 4'b0011, {3'd0, 3'd0, 3'd3, 3'd0}};
      tbl[7]  = '{"csr_lane1",  4'b1111, 16'h0060, 1'b1, 1'b0, 1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}};
      tbl[8]  = '{"prio_mix",   4'b1111, 16'h31CB, 1'b1, 1'b0, 1'b0, 4'b1111, {3'd3, 3'd0, 3'd2, 3'd4}};
      tbl[9]  = '{"stall",      4'b1111, 16'h0000, 1'b1, 1'b1, 1'b0, 4'b0000, 12'd0};
      tbl[10] = '{"brq",        4'b1111, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b0000, 12'd0};
      tbl[11] = '{"inv_lane1",  4'b1111, 16'h0070, 1'b1, 1'b0, 1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}};
      tbl[12] = '{"hole_lane1", 4'b1101, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}};
      tbl[13] = '{"mul2",       4'b1111, 16'h0044, 1'b1, 1'b0, 1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd4}};
      tbl[14] = '{"ff_lane2",   4'b1111, 16'h0800, 1'b1, 1'b0, 1'b0, 4'b0011, {3'd0, 3'd0, 3'd1, 3'd0}};
      tbl[15] = '{"csrdiv_l3",  4'b1111, 16'hA002, 1'b1, 1'b0, 1'b0, 4'b0111, {3'd0, 3'd1, 3'd0, 3'd2}};

      rst = 1'b1; lsu_rdy = 1'b1; stall = 1'b0; csr_done = 1'b0; brq = 1'b0;
      set_lanes(4'b1111, 16'h0000);
      @(posedge clk); #1;
      cyc("reset", 4'b0000, 12'd0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;

      // Single-cycle vectors, all starting and ending in ISSUE with an idle divider.
      for (int i = 0; i < 16; i++) begin
         set_lanes(tbl[i].valid, tbl[i].kinds);
         lsu_rdy = tbl[i].lsu; stall = tbl[i].stl; brq = tbl[i].brq;
         cyc(tbl[i].nm, tbl[i].acc, tbl[i].ports, 1'b0, 1'b0, 1'b0);
      end
      lsu_rdy = 1'b1; stall = 1'b0; brq = 1'b0;

      // Four ALUs: first two go, then the remaining two shift down and go.
      set_lanes(4'b1111, 16'h0000);
      cyc("alu_c1", 4'b0011, {3'd0, 3'd0, 3'd1, 3'd0}, 1'b0, 1'b0, 1'b0);
      set_lanes(4'b0011, 16'h0000);
      cyc("alu_c2", 4'b0011, {3'd0, 3'd0, 3'd1, 3'd0}, 1'b0, 1'b0, 1'b0);

      // CSR serialisation with a csr_complete pulse.
      set_lanes(4'b1111, 16'h0060);
      cyc("csr_pre", 4'b0001, 12'd0, 1'b0, 1'b0, 1'b0);
      set_lanes(4'b0111, 16'h0006);
      cyc("csr_issue", 4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, 1'b0, 1'b0, 1'b0);
      set_lanes(4'b0011, 16'h0000);
      for (int i = 0; i < 3; i++) cyc("wait_ser", 4'b0000, 12'd0, 1'b0, 1'b1, 1'b0);
      csr_done = 1'b1;
      cyc("csr_done", 4'b0000, 12'd0, 1'b0, 1'b1, 1'b0);
      csr_done = 1'b0;
      cyc("csr_resume", 4'b0011, {3'd0, 3'd0, 3'd1, 3'd0}, 1'b0, 1'b0, 1'b0);

      // Stall outranks csr_complete: state is held.
      set_lanes(4'b0001, 16'h0006);
      cyc("csr2_issue", 4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, 1'b0, 1'b0, 1'b0);
      set_lanes(4'b0001, 16'h0000);
      stall = 1'b1; csr_done = 1'b1;
      cyc("stall_done", 4'b0000, 12'd0, 1'b0, 1'b1, 1'b0);
      stall = 1'b0; csr_done = 1'b0;
      cyc("still_wait", 4'b0000, 12'd0, 1'b0, 1'b1, 1'b0);
      csr_done = 1'b1;
      cyc("csr2_done", 4'b0000, 12'd0, 1'b0, 1'b1, 1'b0);
      csr_done = 1'b0;
      cyc("csr2_resume", 4'b0001, 12'd0, 1'b0, 1'b0, 1'b0);

      // Page fault issues alone as EXC; a redirect leaves WAIT_SER.
      set_lanes(4'b0011, 16'h0009);
      cyc("fpage", 4'b0001, {3'd0, 3'd0, 3'd0, 3'd7}, 1'b0, 1'b0, 1'b0);
      set_lanes(4'b0001, 16'h0000);
      cyc("exc_wait", 4'b0000, 12'd0, 1'b0, 1'b1, 1'b0);
      brq = 1'b1;
      cyc("brq_wait", 4'b0000, 12'd0, 1'b0, 1'b1, 1'b0);
      brq = 1'b0;
      cyc("after_brq", 4'b0001, 12'd0, 1'b0, 1'b0, 1'b0);

      // Reset during WAIT_SER.
      set_lanes(4'b0001, 16'h0007);
      cyc("inv_issue", 4'b0001, {3'd0, 3'd0, 3'd0, 3'd7}, 1'b0, 1'b0, 1'b0);
      set_lanes(4'b0001, 16'h0000);
      rst = 1'b1;
      cyc("rst_wait", 4'b0000, 12'd0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      cyc("post_rst", 4'b0001, 12'd0, 1'b0, 1'b0, 1'b0);

      // Divider occupancy: busy t+1..t+34, next DIV at t+35; stall does not pause it.
      set_lanes(4'b0011, 16'h0005);
      cyc("div_issue", 4'b0011, {3'd0, 3'd0, 3'd0, 3'd5}, 1'b0, 1'b0, 1'b0);
      for (int m = 1; m <= 34; m++) begin
         stall = (m >= 10 && m <= 12);
         cyc("div_busy", 4'b0000, 12'd0, 1'b1, 1'b0, 1'b0);
      end
      stall = 1'b0;
      cyc("div_again", 4'b0011, {3'd0, 3'd0, 3'd0, 3'd5}, 1'b0, 1'b0, 1'b0);
      set_lanes(4'b0001, 16'h0000);
      brq = 1'b1;
      cyc("brq_div", 4'b0000, 12'd0, 1'b1, 1'b0, 1'b0);
      brq = 1'b0;
      set_lanes(4'b0000, 16'h0000);
      for (int m = 2; m <= 24; m++) cyc("div_count", 4'b0000, 12'd0, 1'b1, 1'b0, 1'b0);
      // Counter is now 10; reset drops it and a DIV can go straight away.
      set_lanes(4'b0001, 16'h0000);
      rst = 1'b1;
      cyc("rst_div", 4'b0000, 12'd0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      set_lanes(4'b0011, 16'h0050);
      cyc("post_rst_div", 4'b0011, {3'd0, 3'd0, 3'd5, 3'd0}, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
